mod503_inverse: RTL

MOD503_INVERSE -- requirements
Module: mod503_inverse

---
 rtl/mod503_pkg.sv | 15 +
 rtl/mod503_mul.sv | 26 ++
 rtl/mod503_inverse.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mod503_pkg.sv
// Shared constants and FSM state encoding for the mod-503 inverter.
package mod503_pkg;

  localparam int unsigned MOD503_P   = 503;
  localparam int unsigned MOD503_EXP = 501;
  localparam int unsigned MOD503_W   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } mod503_state_e;

endpackage : mod503_pkg

// File: rtl/mod503_mul.sv
// Combinational modular multiplier: r = (a * b) mod P.
// Ports: a, b - W-bit residues; r - W-bit reduced product.
module mod503_mul
  import mod503_pkg::*;
#(
  parameter int unsigned W = MOD503_W,
  parameter int unsigned P = MOD503_P
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] prod;
  logic [PW-1:0] rem;

  // Full-width product first, then a single reduction.
  always_comb begin
    prod = PW'(a) * PW'(b);
    rem  = prod % PW'(P);
    r    = W'(rem);
  end

endmodule : mod503_mul

// File: rtl/mod503_inverse.sv
// Modular inverse a^-1 mod P via Fermat: a^(P-2), left-to-right
// square-and-multiply using one shared multiplier, one product per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a operand
// handshake; out_valid/out_ready/inv/err result handshake. err flags an
// operand of 0 or >= P (inv reads 0 in that case).
module mod503_inverse
  import mod503_pkg::*;
#(
  parameter int unsigned W = MOD503_W,
  parameter int unsigned P = MOD503_P
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] inv,
  output logic         err
);

  localparam int unsigned IDX_W = $clog2(W);
  // Exponent P-2 has its MSB at bit W-1; scanning starts one bit below.
  localparam logic [W-1:0]     EXP_BITS  = W'(P - 2);
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(W - 2);

  mod503_state_e    state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     base_q, base_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     inv_d;
  logic             err_d;
  logic             out_valid_d;
  logic             in_ready_d;

  logic [W-1:0]     mul_b;
  logic [W-1:0]     prod;

  mod503_mul #(.W(W), .P(P)) u_mul (
    .a (acc_q),
    .b (mul_b),
    .r (prod)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      inv       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      inv       <= inv_d;
      err       <= err_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    idx_d   = idx_q;
    inv_d   = inv;
    err_d   = err;
    mul_b   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((a != '0) && (a < W'(P))) begin
            state_d = SQR;
            acc_d   = a;
            base_d  = a;
            idx_d   = START_IDX;
          end else begin
            state_d = DONE;
            inv_d   = '0;
            err_d   = 1'b1;
          end
        end
      end

      SQR: begin
        mul_b = acc_q;
        acc_d = prod;
        if (EXP_BITS[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = DONE;
          inv_d   = prod;
          err_d   = 1'b0;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      MUL: begin
        mul_b = base_q;
        acc_d = prod;
        if (idx_q == '0) begin
          state_d = DONE;
          inv_d   = prod;
          err_d   = 1'b0;
        end else begin
          state_d = SQR;
          idx_d   = idx_q - IDX_W'(1);
        end
      end

      DONE: begin
        // Result stays put until the consumer takes it.
        if (out_ready) begin
          state_d = IDLE;
          inv_d   = '0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        inv_d   = '0;
        err_d   = 1'b0;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

endmodule : mod503_inverse
